ram_stream_reader: RTL

- Read-side engine for the team's inferred simple dual-port RAM (registered read, one-cycle latency, old-data on collision).
- Takes a burst command (base address, length) and sweeps the RAM read port.
- Presents the words in order on a valid/ready output stream.
- Absorbs the RAM read latency and downstream backpressure with a small credit-based output FIFO.

---
 rtl/ram_stream_reader.sv | 126 ++++++++++++
 1 files changed

// File: rtl/ram_stream_reader.sv
// Burst read engine: sweeps a registered-read RAM port from a captured base/len
// and streams the words out through a credit-limited valid/ready FIFO.
module ram_stream_reader #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   len,
    output logic                  busy,
    output logic                  done,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_q,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] MAX_LEN = CW'(1) << ADDR_WIDTH;
    localparam logic [PW:0]   CREDITS = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [CW-1:0]         len_q;
    logic [CW-1:0]         issued;
    logic [CW-1:0]         popped;
    logic [CW-1:0]         popped_nxt;
    logic [PW:0]           outstanding;
    logic                  rd_pend;
    logic                  accept;
    logic                  pop;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [PW:0]           count;

    assign out_valid  = (count != '0);
    assign out_data   = mem[rd_ptr];
    assign pop        = out_valid && out_ready;
    assign popped_nxt = popped + CW'(pop);

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        rd_en     = 1'b0;
        rd_addr   = '0;
        accept    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = (len == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                busy    = 1'b1;
                // outstanding counts reads in flight plus words buffered, so
                // stalling at FIFO_DEPTH guarantees every return has a slot
                rd_en   = (issued < len_q) && (outstanding < CREDITS);
                rd_addr = base_q + issued[ADDR_WIDTH-1:0];
                if ((issued == len_q) && (popped_nxt == len_q))
                    state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q      <= '0;
            len_q       <= '0;
            issued      <= '0;
            popped      <= '0;
            outstanding <= '0;
            rd_pend     <= 1'b0;
        end else begin
            if (accept) begin
                base_q <= base_addr;
                len_q  <= (len > MAX_LEN) ? MAX_LEN : len;
                issued <= '0;
                popped <= '0;
            end else begin
                if (rd_en) issued <= issued + CW'(1);
                popped <= popped_nxt;
            end
            outstanding <= outstanding + (PW + 1)'(rd_en) - (PW + 1)'(pop);
            rd_pend     <= rd_en;
        end
    end

    // Return path: ram_q is valid the cycle after rd_en and lands in the FIFO then
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (rd_pend) begin
                mem[wr_ptr] <= ram_q;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            count <= count + (PW + 1)'(rd_pend) - (PW + 1)'(pop);
        end
    end

endmodule
